apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave.sv | 156 +++++++++++++++
 tb/tb_apb_mem_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB slave that maps byte/half-word/word transfers onto a 4-lane, synchronous-read
// memory port, with optional wait states, range/alignment errors and abort handling.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [1:0]            strobe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  slverr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_wr,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [1:0]            dbg_state   // 0 IDLE, 1 WAIT, 2 MEM, 3 RESP
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MEM  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(WAIT_STATES + 2);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

  state_t                state, state_n;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  lat_write;
  logic [1:0]            lat_strobe;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_err;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  setup;
  logic                  active;
  logic                  err_now;
  logic [4:0]            lane_shift;
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] rd_mask;

  // Handshake: a transfer starts with one setup cycle (sel=1, enable=0) seen in IDLE;
  // the master then holds sel=1, enable=1 until ready=1 for one cycle. Losing either
  // sel or enable before that abandons the transfer without a response.
  assign setup  = (state == IDLE) && sel && !enable;
  assign active = sel && enable;

  always_comb begin
    err_now = 1'b0;
    if (strobe == 2'b11)                        err_now = 1'b1;
    if ({1'b0, addr} >= MEM_LIMIT)              err_now = 1'b1;
    if (strobe == 2'b01 && addr[0])             err_now = 1'b1;
    if (strobe == 2'b10 && addr[1:0] != 2'b00) err_now = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_write  <= 1'b0;
      lat_strobe <= 2'b00;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_err    <= 1'b0;
      addr_hold  <= '0;
    end else begin
      state <= state_n;
      if (setup) begin
        lat_write  <= write;
        lat_strobe <= strobe;
        lat_addr   <= addr;
        lat_wdata  <= wdata;
        lat_err    <= err_now;
        wait_cnt   <= CNT_W'(WAIT_STATES);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      // The memory address stays on the bus after MEM so the RAM output remains stable.
      if (state == MEM) begin
        addr_hold <= {lat_addr[ADDR_WIDTH-1:2], 2'b00};
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (setup) begin
          if (WAIT_STATES > 0) state_n = WAIT;
          else if (err_now)    state_n = RESP;
          else                 state_n = MEM;
        end
      end
      WAIT: begin
        if (!active)                        state_n = IDLE;
        else if (wait_cnt <= CNT_W'(1))     state_n = lat_err ? RESP : MEM;
      end
      MEM:     state_n = active ? RESP : IDLE;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign lane_shift = {lat_addr[1:0], 3'b000};
  assign rd_shifted = mem_data_out >> lane_shift;

  always_comb begin
    rd_mask = '1;
    case (lat_strobe)
      2'b00:   rd_mask = DATA_WIDTH'(8'hFF);
      2'b01:   rd_mask = DATA_WIDTH'(16'hFFFF);
      default: rd_mask = '1;
    endcase
  end

  always_comb begin
    mem_wr      = 1'b0;
    mem_be      = 4'b0000;
    mem_data_in = '0;
    mem_address = addr_hold;
    ready       = 1'b0;
    slverr      = 1'b0;
    rdata       = '0;
    if (state == MEM) begin
      mem_wr      = lat_write;
      mem_address = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_data_in = lat_wdata << lane_shift;
      case (lat_strobe)
        2'b00:   mem_be = 4'b0001 << lat_addr[1:0];
        2'b01:   mem_be = 4'b0011 << lat_addr[1:0];
        default: mem_be = 4'b1111;
      endcase
    end
    // Read data arrives from the synchronous RAM one cycle after MEM, i.e. in RESP.
    if (state == RESP) begin
      ready  = 1'b1;
      slverr = lat_err;
      if (!lat_write && !lat_err) rdata = rd_shifted & rd_mask;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 2 and 3 wait states), each with a RAM,
// checked against a byte-addressed reference memory through response/memory queues.
module tb_apb_mem_slave;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NDUT-1:0] sel_v;
  logic enable, write;
  logic [1:0] strobe;
  logic [31:0] addr, wdata;
  logic [NDUT-1:0] ready_v, slverr_v, mem_wr_v;
  logic [NDUT-1:0][31:0] rdata_v, mem_address_v, mem_data_in_v;
  logic [NDUT-1:0][3:0] mem_be_v;
  logic [NDUT-1:0][1:0] dbg_state_v;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // {dut[1:0], slverr, rdata[31:0], cycle[31:0]}
  logic [66:0] exp_q[$];
  // {dut[1:0], wr, be[3:0], address[31:0], data_in[31:0], cycle[31:0]}
  logic [102:0] mexp_q[$];
  logic [7:0] ref_mem [NDUT][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic [31:0] ram [256];
    logic [31:0] mdo;

    apb_mem_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(1024), .WAIT_STATES(WS)
    ) u_dut (
      .clk(clk), .rst(rst), .sel(sel_v[g]), .enable(enable), .write(write),
      .strobe(strobe), .addr(addr), .wdata(wdata),
      .ready(ready_v[g]), .slverr(slverr_v[g]), .rdata(rdata_v[g]),
      .mem_wr(mem_wr_v[g]), .mem_be(mem_be_v[g]), .mem_address(mem_address_v[g]),
      .mem_data_in(mem_data_in_v[g]), .mem_data_out(mdo), .dbg_state(dbg_state_v[g])
    );

    always @(posedge clk) begin
      if (cyc < 2) begin
        for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        mdo <= 32'h0;
      end else begin
        if (mem_wr_v[g]) begin
          for (int l = 0; l < 4; l++)
            if (mem_be_v[g][l]) ram[mem_address_v[g][9:2]][8*l +: 8] <= mem_data_in_v[g][8*l +: 8];
        end
        mdo <= ram[mem_address_v[g][9:2]];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT responds or runs a memory cycle.
  logic [66:0] e;
  logic [102:0] m;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < NDUT; d++) begin
        if (ready_v[d] === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'(d), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("resp_dut", 64'(d), 64'(e[66:65]));
            check("resp_slverr", 64'(slverr_v[d]), 64'(e[64]));
            check("resp_rdata", 64'(rdata_v[d]), 64'(e[63:32]));
            check("resp_cycle", 64'(cyc), 64'(e[31:0]));
          end
        end else begin
          check("idle_resp_zero", 64'({slverr_v[d], rdata_v[d]}), 64'h0);
        end
        if (mem_be_v[d] !== 4'b0000) begin
          if (mexp_q.size() == 0) begin
            check("unexpected_mem", 64'(d), 64'hFFFF);
          end else begin
            m = mexp_q.pop_front();
            check("mem_dut", 64'(d), 64'(m[102:101]));
            check("mem_wr", 64'(mem_wr_v[d]), 64'(m[100]));
            check("mem_be", 64'(mem_be_v[d]), 64'(m[99:96]));
            check("mem_address", 64'(mem_address_v[d]), 64'(m[95:64]));
            check("mem_data_in", 64'(mem_data_in_v[d]), 64'(m[63:32]));
            check("mem_cycle", 64'(cyc), 64'(m[31:0]));
          end
        end else begin
          check("idle_mem_zero", 64'({mem_wr_v[d], mem_data_in_v[d]}), 64'h0);
        end
      end
    end
  end

  // Drives a setup phase and pushes what the reference model predicts for it.
  task automatic setup(input int d, input bit wr, input bit [1:0] sz, input bit [31:0] a,
                       input bit [31:0] wd, input bit push_resp, input bit push_mem);
    int ws, nb, t0;
    bit err;
    logic [31:0] rd;
    logic [3:0] be;
    ws = (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    sel_v = '0;
    sel_v[d] = 1'b1;
    enable = 1'b0;
    write = wr;
    strobe = sz;
    addr = a;
    wdata = wd;
    t0 = cyc;
    err = (sz == 2'b11) || (a >= 32'd1024) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00);
    nb = 1 << sz;
    rd = '0;
    be = '0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        be[(a % 4) + i] = 1'b1;
        if (!wr) rd[8*i +: 8] = ref_mem[d][a + i];
      end
    end
    if (push_mem && !err) begin
      mexp_q.push_back({2'(d), wr, be, a & ~32'h3, 32'(wd << (8 * (a % 4))), 32'(t0 + 1 + ws)});
      if (wr) for (int i = 0; i < nb; i++) ref_mem[d][a + i] = wd[8*i +: 8];
    end
    if (push_resp) exp_q.push_back({2'(d), err, rd, 32'(t0 + (err ? 1 : 2) + ws)});
  endtask

  task automatic access(input int d);
    int n;
    @(posedge clk); #1;
    enable = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (ready_v[d] === 1'b1) break;
      n++;
    end
    if (n == 20) check("ready_timeout", 64'(d), 64'hFFFF);
    @(posedge clk); #1;
  endtask

  task automatic xfer(input int d, input bit wr, input bit [1:0] sz, input bit [31:0] a,
                      input bit [31:0] wd);
    setup(d, wr, sz, a, wd, 1'b1, 1'b1);
    access(d);
  endtask

  task automatic idle(input int n);
    sel_v = '0;
    enable = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_ignored(input int d);
    sel_v = '0;
    sel_v[d] = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    sel_v = '0;
    enable = 1'b0;
    @(negedge clk);
    check("ignored_state_idle", 64'(dbg_state_v[d]), 64'h0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input int d, input string tag);
    check({tag, "_ready"}, 64'(ready_v[d]), 64'h0);
    check({tag, "_slverr"}, 64'(slverr_v[d]), 64'h0);
    check({tag, "_rdata"}, 64'(rdata_v[d]), 64'h0);
    check({tag, "_mem_wr"}, 64'(mem_wr_v[d]), 64'h0);
    check({tag, "_mem_be"}, 64'(mem_be_v[d]), 64'h0);
    check({tag, "_mem_address"}, 64'(mem_address_v[d]), 64'h0);
    check({tag, "_mem_data_in"}, 64'(mem_data_in_v[d]), 64'h0);
    check({tag, "_state"}, 64'(dbg_state_v[d]), 64'h0);
  endtask

  int rd_dut, gap;
  bit rwr;
  bit [1:0] rsz;
  bit [31:0] ra, rwd;

  initial begin
    rst = 1'b1;
    sel_v = '0;
    enable = 1'b0;
    write = 1'b0;
    strobe = 2'b00;
    addr = '0;
    wdata = '0;
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 1024; i++) ref_mem[d][i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_all_zero(d, "reset");

    // Setup phase presented in the same cycle reset is released.
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b1, 2'b10, 32'h10, 32'hAABBCCDD);
    xfer(0, 1'b0, 2'b00, 32'h13, 32'h0);
    xfer(0, 1'b1, 2'b01, 32'h21, 32'h5A5A);
    xfer(0, 1'b0, 2'b10, 32'h400, 32'h0);
    xfer(0, 1'b1, 2'b10, 32'h3FC, 32'h01020304);
    xfer(0, 1'b0, 2'b01, 32'h3FE, 32'h0);
    xfer(0, 1'b0, 2'b11, 32'h8, 32'h0);
    xfer(2, 1'b1, 2'b01, 32'h2, 32'h1234);
    xfer(2, 1'b0, 2'b10, 32'h0, 32'h0);
    xfer(1, 1'b0, 2'b10, 32'h401, 32'h0);

    // Abort in WAIT on the two-wait-state instance.
    idle(1);
    setup(1, 1'b1, 2'b10, 32'h40, 32'h5555AAAA, 1'b0, 1'b0);
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    sel_v = '0;
    @(negedge clk);
    check("abort_state_idle", 64'(dbg_state_v[1]), 64'h0);
    idle(6);
    xfer(1, 1'b0, 2'b10, 32'h40, 32'h0);

    // Reset asserted while instance 0 is in its MEM cycle.
    idle(1);
    setup(0, 1'b1, 2'b10, 32'h44, 32'h0BADF00D, 1'b0, 1'b1);
    @(posedge clk); #1;
    enable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    sel_v = '0;
    enable = 1'b0;
    @(negedge clk);
    check_all_zero(0, "rst_in_mem");
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 1'b0, 2'b10, 32'h44, 32'h0);

    pulse_ignored(0);
    pulse_ignored(2);

    for (int k = 0; k < 200; k++) begin
      rd_dut = $urandom_range(0, 2);
      rwr = 1'($urandom_range(0, 1));
      rsz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ra = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'b10) ra[1:0] = 2'b00;
        else if (rsz == 2'b01) ra[0] = 1'b0;
      end
      if ($urandom_range(0, 11) == 0) ra = 32'd1024 + $urandom_range(0, 255);
      rwd = $urandom;
      xfer(rd_dut, rwr, rsz, ra, rwd);
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) pulse_ignored(rd_dut);
      else if (gap > 0) idle(gap);
    end

    idle(20);
    check("resp_queue_drained", 64'(exp_q.size()), 64'h0);
    check("mem_queue_drained", 64'(mexp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
